// File: rtl/stream_pkg.sv
// Shared types for the round-robin stream merge: data-width default, FSM states, RR pointer.
package stream_pkg;

    localparam int STREAM_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    typedef enum logic {
        RR_A,
        RR_B
    } rr_e;

endpackage

// File: rtl/stream_rr_merge_if.sv
// AXI-stream style data/valid/ready bundle used for both merge inputs and the merged output.
interface stream_rr_merge_if
    import stream_pkg::*;
#(
    parameter int DATA_W = STREAM_DATA_W
);

    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/stream_fifo2.sv
// Two-entry synchronous FIFO with occupancy output; caller never pushes when full or pops when empty.
module stream_fifo2
    import stream_pkg::*;
#(
    parameter int DATA_W = STREAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        cnt_q;

    // NOTE: storage is reset too, so the head reads zero out of reset instead of X.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            // NOTE: non-blocking everywhere here so every register sees pre-edge values.
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign count = cnt_q;

endmodule

// File: rtl/stream_rr_merge.sv
// Round-robin merge of two streams into one, with ap_start/ap_done control over NUM_WORDS words per run.
module stream_rr_merge
    import stream_pkg::*;
#(
    parameter int DATA_W    = STREAM_DATA_W,
    parameter int NUM_WORDS = 1024,
    parameter int CNT_W     = $clog2(NUM_WORDS + 1)
) (
    input  logic ap_clk,
    input  logic ap_rst,
    input  logic ap_start,
    output logic ap_done,
    output logic ap_idle,
    output logic ap_ready,
    stream_rr_merge_if.slave  Input_1_V,
    stream_rr_merge_if.slave  Input_2_V,
    stream_rr_merge_if.master Output_1_V
);

    localparam logic [CNT_W-1:0] WORDS      = CNT_W'(NUM_WORDS);
    localparam logic [CNT_W-1:0] WORDS_LAST = CNT_W'(NUM_WORDS - 1);

    state_e            state_q;
    state_e            state_d;
    rr_e               rr_q;
    logic [CNT_W-1:0]  acc_cnt;
    logic [CNT_W-1:0]  snd_cnt;
    logic [1:0]        fifo_count;
    logic              can_accept;
    logic              grant_a;
    logic              grant_b;
    logic              push;
    logic              pop;
    logic              last_send;
    logic              run_start;
    logic [DATA_W-1:0] push_data;

    // Admission uses only registered state, so input ready never sees the output ready.
    assign can_accept = (state_q == ST_RUN) && (acc_cnt < WORDS) && (fifo_count < 2'd2);
    assign grant_a    = can_accept && Input_1_V.tvalid && (!Input_2_V.tvalid || rr_q == RR_A);
    assign grant_b    = can_accept && Input_2_V.tvalid && (!Input_1_V.tvalid || rr_q == RR_B);

    assign Input_1_V.tready = grant_a;
    assign Input_2_V.tready = grant_b;

    assign push      = grant_a || grant_b;
    assign push_data = grant_a ? Input_1_V.tdata : Input_2_V.tdata;
    assign pop       = Output_1_V.tvalid && Output_1_V.tready;
    assign last_send = pop && (snd_cnt == WORDS_LAST);
    assign run_start = (state_q == ST_IDLE) && ap_start;

    stream_fifo2 #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk   (ap_clk),
        .rst   (ap_rst),
        .push  (push),
        .din   (push_data),
        .pop   (pop),
        .dout  (Output_1_V.tdata),
        .count (fifo_count)
    );

    assign Output_1_V.tvalid = (fifo_count != 2'd0);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: next state defaults to current state first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (ap_start) state_d = ST_RUN;
            ST_RUN:  if (last_send) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            acc_cnt <= '0;
            snd_cnt <= '0;
            rr_q    <= RR_A;
        end else if (run_start) begin
            acc_cnt <= '0;
            snd_cnt <= '0;
            rr_q    <= RR_A;
        end else begin
            if (push) begin
                acc_cnt <= acc_cnt + CNT_W'(1);
                rr_q    <= grant_a ? RR_B : RR_A;
            end
            if (pop) begin
                snd_cnt <= snd_cnt + CNT_W'(1);
            end
        end
    end

    assign ap_idle  = (state_q == ST_IDLE);
    assign ap_done  = (state_q == ST_DONE);
    assign ap_ready = (state_q == ST_DONE);

endmodule

// File: tb/tb_stream_rr_merge.sv
// Directed scenario bench for stream_rr_merge with NUM_WORDS=4 and hand-computed word order and timing.
module tb_stream_rr_merge;

    localparam int DATA_W    = 32;
    localparam int NUM_WORDS = 4;

    logic ap_clk = 1'b0;
    logic ap_rst;
    logic ap_start;
    logic ap_done;
    logic ap_idle;
    logic ap_ready;

    stream_rr_merge_if #(.DATA_W(DATA_W)) in_a ();
    stream_rr_merge_if #(.DATA_W(DATA_W)) in_b ();
    stream_rr_merge_if #(.DATA_W(DATA_W)) out_s ();

    stream_rr_merge #(
        .DATA_W    (DATA_W),
        .NUM_WORDS (NUM_WORDS)
    ) dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .ap_start   (ap_start),
        .ap_done    (ap_done),
        .ap_idle    (ap_idle),
        .ap_ready   (ap_ready),
        .Input_1_V  (in_a),
        .Input_2_V  (in_b),
        .Output_1_V (out_s)
    );

    always #5 ap_clk = ~ap_clk;

    int checks   = 0;
    int failures = 0;

    int          cyc;
    int          a_idx;
    int          b_idx;
    bit          a_en;
    bit          b_en;
    logic [31:0] got_q [$];
    int          got_cyc_q [$];
    int          done_cnt;
    int          last_done_cyc;
    int          rdy_mis;
    int          a_rdy_cnt;
    int          b_rdy_cnt;
    int          idle_cnt;
    int          hs_in_cnt;
    int          stall_chg;
    logic        prev_stall;
    logic [31:0] prev_data;

    task automatic clear_log();
        cyc           = 0;
        a_idx         = 0;
        b_idx         = 0;
        got_q.delete();
        got_cyc_q.delete();
        done_cnt      = 0;
        last_done_cyc = -1;
        rdy_mis       = 0;
        a_rdy_cnt     = 0;
        b_rdy_cnt     = 0;
        idle_cnt      = 0;
        hs_in_cnt     = 0;
        stall_chg     = 0;
        prev_stall    = 1'b0;
        prev_data     = '0;
    endtask

    // One clock cycle: called at posedge+1, applies sources, observes, advances past the next edge.
    task automatic tick();
        logic a_hs, b_hs, o_hs;
        in_a.tdata  = 32'hA0 + 32'(a_idx);
        in_a.tvalid = a_en;
        in_b.tdata  = 32'hB0 + 32'(b_idx);
        in_b.tvalid = b_en;
        #1;
        a_hs = in_a.tvalid && in_a.tready;
        b_hs = in_b.tvalid && in_b.tready;
        o_hs = out_s.tvalid && out_s.tready;
        if (prev_stall && out_s.tdata !== prev_data) stall_chg++;
        prev_stall = out_s.tvalid && !out_s.tready;
        prev_data  = out_s.tdata;
        if (o_hs) begin
            got_q.push_back(out_s.tdata);
            got_cyc_q.push_back(cyc);
        end
        if (ap_done === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (ap_ready !== ap_done) rdy_mis++;
        if (in_a.tready === 1'b1) a_rdy_cnt++;
        if (in_b.tready === 1'b1) b_rdy_cnt++;
        if (ap_idle === 1'b1) idle_cnt++;
        @(posedge ap_clk);
        #1;
        if (a_hs) a_idx++;
        if (b_hs) b_idx++;
        hs_in_cnt += int'(a_hs) + int'(b_hs);
        cyc++;
    endtask

    task automatic run_until_done(input int target, output bit ok);
        int n;
        n = 0;
        while (done_cnt < target && n < 60) begin
            tick();
            n++;
        end
        ok = (done_cnt >= target);
    endtask

    task automatic test_reset();
        ap_rst          = 1'b1;
        a_en            = 1'b1;
        b_en            = 1'b1;
        out_s.tready    = 1'b1;
        tick();
        checks++; if (ap_idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b exp=1", ap_idle); end
        checks++; if (ap_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", ap_done); end
        checks++; if (ap_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ap_ready); end
        checks++; if (in_a.tready !== 1'b0 || in_b.tready !== 1'b0) begin
            failures++; $display("FAIL reset_treadys got=%b%b exp=00", in_a.tready, in_b.tready);
        end
        checks++; if (out_s.tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b exp=0", out_s.tvalid); end
        checks++; if (out_s.tdata !== 32'h0) begin failures++; $display("FAIL reset_tdata got=%h exp=0", out_s.tdata); end
        ap_rst = 1'b0;
        a_en   = 1'b0;
        b_en   = 1'b0;
        tick();
    endtask

    task automatic test_fair();
        logic [31:0] exp_w [4];
        logic [31:0] g;
        bit ok;
        exp_w = '{32'hA0, 32'hB0, 32'hA1, 32'hB1};
        clear_log();
        a_en = 1'b1; b_en = 1'b1; out_s.tready = 1'b1;
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        run_until_done(1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL fair_timeout got=%0d done pulses exp=1", done_cnt); end
        checks++; if (got_q.size() != 4) begin failures++; $display("FAIL fair_count got=%0d exp=4", got_q.size()); end
        for (int i = 0; i < 4; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 32'hx;
            checks++; if (g !== exp_w[i]) begin failures++; $display("FAIL fair_word%0d got=%h exp=%h", i, g, exp_w[i]); end
            if (i < got_cyc_q.size()) begin
                checks++; if (got_cyc_q[i] != 2 + i) begin failures++; $display("FAIL fair_cycle%0d got=%0d exp=%0d", i, got_cyc_q[i], 2 + i); end
            end
        end
        checks++; if (last_done_cyc != 6) begin failures++; $display("FAIL fair_done_cycle got=%0d exp=6", last_done_cyc); end
        checks++; if (rdy_mis != 0) begin failures++; $display("FAIL fair_ready_vs_done got=%0d exp=0", rdy_mis); end
        checks++; if (a_rdy_cnt != 2 || b_rdy_cnt != 2) begin
            failures++; $display("FAIL fair_grants got=%0d/%0d exp=2/2", a_rdy_cnt, b_rdy_cnt);
        end
        checks++; if (in_a.tready !== 1'b0 || in_b.tready !== 1'b0 || ap_idle !== 1'b1) begin
            failures++; $display("FAIL fair_after got=%b%b idle=%b exp=00 idle=1", in_a.tready, in_b.tready, ap_idle);
        end
    endtask

    task automatic test_single();
        logic [31:0] g;
        bit ok;
        clear_log();
        a_en = 1'b0; b_en = 1'b1; out_s.tready = 1'b1;
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        run_until_done(1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_timeout got=%0d exp=1", done_cnt); end
        checks++; if (got_q.size() != 4) begin failures++; $display("FAIL single_count got=%0d exp=4", got_q.size()); end
        for (int i = 0; i < 4; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 32'hx;
            checks++; if (g !== 32'hB0 + 32'(i)) begin failures++; $display("FAIL single_word%0d got=%h exp=%h", i, g, 32'hB0 + 32'(i)); end
            if (i < got_cyc_q.size()) begin
                checks++; if (got_cyc_q[i] != 2 + i) begin failures++; $display("FAIL single_cycle%0d got=%0d exp=%0d", i, got_cyc_q[i], 2 + i); end
            end
        end
        checks++; if (a_rdy_cnt != 0) begin failures++; $display("FAIL single_a_tready got=%0d exp=0", a_rdy_cnt); end
        checks++; if (last_done_cyc != 6) begin failures++; $display("FAIL single_done_cycle got=%0d exp=6", last_done_cyc); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_w [4];
        logic [31:0] g;
        bit ok;
        exp_w = '{32'hA0, 32'hB0, 32'hA1, 32'hB1};
        clear_log();
        a_en = 1'b1; b_en = 1'b1; out_s.tready = 1'b0;
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        repeat (5) tick();
        checks++; if (hs_in_cnt != 2) begin failures++; $display("FAIL bp_accepted got=%0d exp=2", hs_in_cnt); end
        checks++; if (in_a.tready !== 1'b0 || in_b.tready !== 1'b0) begin
            failures++; $display("FAIL bp_treadys got=%b%b exp=00", in_a.tready, in_b.tready);
        end
        checks++; if (out_s.tvalid !== 1'b1 || out_s.tdata !== 32'hA0) begin
            failures++; $display("FAIL bp_head got=%b/%h exp=1/a0", out_s.tvalid, out_s.tdata);
        end
        checks++; if (stall_chg != 0) begin failures++; $display("FAIL bp_stable got=%0d changes exp=0", stall_chg); end
        out_s.tready = 1'b1;
        run_until_done(1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL bp_timeout got=%0d exp=1", done_cnt); end
        checks++; if (got_q.size() != 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", got_q.size()); end
        for (int i = 0; i < 4; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 32'hx;
            checks++; if (g !== exp_w[i]) begin failures++; $display("FAIL bp_word%0d got=%h exp=%h", i, g, exp_w[i]); end
        end
        checks++; if (last_done_cyc != 10) begin failures++; $display("FAIL bp_done_cycle got=%0d exp=10", last_done_cyc); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp_w [4];
        logic [31:0] g;
        bit ok;
        int n;
        exp_w = '{32'hA0, 32'hB0, 32'hA1, 32'hB1};
        clear_log();
        a_en = 1'b1; b_en = 1'b1; out_s.tready = 1'b1;
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        n = 0;
        while (got_q.size() < 2 && n < 20) begin
            tick();
            n++;
        end
        checks++; if (got_q.size() < 2) begin failures++; $display("FAIL rmid_wait got=%0d exp=2", got_q.size()); end
        ap_rst = 1'b1;
        tick();
        checks++; if (out_s.tvalid !== 1'b0) begin failures++; $display("FAIL rmid_tvalid got=%b exp=0", out_s.tvalid); end
        checks++; if (ap_idle !== 1'b1) begin failures++; $display("FAIL rmid_idle got=%b exp=1", ap_idle); end
        checks++; if (done_cnt != 0) begin failures++; $display("FAIL rmid_no_done got=%0d exp=0", done_cnt); end
        ap_rst = 1'b0;
        clear_log();
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        run_until_done(1, ok);
        checks++; if (!ok || done_cnt != 1) begin failures++; $display("FAIL rmid_rerun_done got=%0d exp=1", done_cnt); end
        checks++; if (got_q.size() != 4) begin failures++; $display("FAIL rmid_count got=%0d exp=4", got_q.size()); end
        for (int i = 0; i < 4; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 32'hx;
            checks++; if (g !== exp_w[i]) begin failures++; $display("FAIL rmid_word%0d got=%h exp=%h", i, g, exp_w[i]); end
        end
    endtask

    task automatic test_start_held();
        logic [31:0] g;
        logic [31:0] e;
        bit ok;
        clear_log();
        a_en = 1'b1; b_en = 1'b1; out_s.tready = 1'b1;
        ap_start = 1'b1;
        run_until_done(2, ok);
        ap_start = 1'b0;
        checks++; if (!ok || done_cnt != 2) begin failures++; $display("FAIL held_done_pulses got=%0d exp=2", done_cnt); end
        checks++; if (got_q.size() != 2 * NUM_WORDS) begin failures++; $display("FAIL held_count got=%0d exp=%0d", got_q.size(), 2 * NUM_WORDS); end
        for (int i = 0; i < 2 * NUM_WORDS; i++) begin
            e = ((i % 2) == 0) ? 32'hA0 + 32'(i / 2) : 32'hB0 + 32'(i / 2);
            g = (i < got_q.size()) ? got_q[i] : 32'hx;
            checks++; if (g !== e) begin failures++; $display("FAIL held_word%0d got=%h exp=%h", i, g, e); end
        end
        checks++; if (idle_cnt != 2) begin failures++; $display("FAIL held_idle_cycles got=%0d exp=2", idle_cnt); end
        if (got_cyc_q.size() > 4) begin
            checks++; if (got_cyc_q[4] != 9) begin failures++; $display("FAIL held_run2_first got=%0d exp=9", got_cyc_q[4]); end
        end
        checks++; if (last_done_cyc != 13) begin failures++; $display("FAIL held_done_cycle got=%0d exp=13", last_done_cyc); end
        tick();
        checks++; if (ap_idle !== 1'b1) begin failures++; $display("FAIL held_release_idle got=%b exp=1", ap_idle); end
    endtask

    task automatic test_no_data();
        logic [31:0] g;
        bit ok;
        clear_log();
        a_en = 1'b0; b_en = 1'b0; out_s.tready = 1'b1;
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        repeat (6) tick();
        checks++; if (ap_idle !== 1'b0) begin failures++; $display("FAIL nodata_idle got=%b exp=0", ap_idle); end
        checks++; if (got_q.size() != 0 || out_s.tvalid !== 1'b0) begin
            failures++; $display("FAIL nodata_output got=%0d words tvalid=%b exp=0/0", got_q.size(), out_s.tvalid);
        end
        checks++; if (done_cnt != 0) begin failures++; $display("FAIL nodata_done got=%0d exp=0", done_cnt); end
        b_en = 1'b1;
        run_until_done(1, ok);
        checks++; if (!ok || done_cnt != 1) begin failures++; $display("FAIL nodata_late_done got=%0d exp=1", done_cnt); end
        checks++; if (got_q.size() != 4) begin failures++; $display("FAIL nodata_count got=%0d exp=4", got_q.size()); end
        for (int i = 0; i < 4; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 32'hx;
            checks++; if (g !== 32'hB0 + 32'(i)) begin failures++; $display("FAIL nodata_word%0d got=%h exp=%h", i, g, 32'hB0 + 32'(i)); end
        end
    endtask

    initial begin
        ap_rst       = 1'b1;
        ap_start     = 1'b0;
        a_en         = 1'b0;
        b_en         = 1'b0;
        in_a.tdata   = '0;
        in_a.tvalid  = 1'b0;
        in_b.tdata   = '0;
        in_b.tvalid  = 1'b0;
        out_s.tready = 1'b0;
        clear_log();
        repeat (3) @(posedge ap_clk);
        #1;
        test_reset();
        test_fair();
        test_single();
        test_backpressure();
        test_reset_mid();
        test_start_held();
        test_no_data();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
